emif_avmm_mem_chkr: RTL and testbench
=====================================

# emif_avmm_mem_chkr

AVMM initiator that drives the user side of the EMIF AVMM bus to self-test one DDR4 channel. On release of the CSR clear it writes a deterministic pattern over a configurable region in bursts, reads the region back, and compares every beat. It sits between the EMIF AVMM port and the FME sideband status/control signals (`chkr_clear_n`, `clear_busy`, `chkr_error`).

## Interface
- `ADDR_WIDTH`, default `ofs_fim_emif_cfg_pkg::AVMM_ADDR_WIDTH`: word address width.
- `DATA_WIDTH`, default `ofs_fim_emif_cfg_pkg::AVMM_DATA_WIDTH`: beat width. Must be a multiple of 32.
- `BURSTCOUNT_WIDTH`, default `ofs_fim_emif_cfg_pkg::AVMM_BURSTCOUNT_WIDTH`: burstcount width.
- `BYTEENABLE_WIDTH`, default `ofs_fim_emif_cfg_pkg::AVMM_BYTEENABLE_WIDTH`: byteenable width.
- `BASE_ADDR`, default 0: first word address tested.
- `BURST_LEN`, default 4: beats per burst. Range 1..2^(BURSTCOUNT_WIDTH-1).
- `NUM_BURSTS`, default 1024: bursts per pass.
- `MAX_OUTSTANDING`, default 8: maximum read bursts in flight.

Ports:
- `clk` in 1: EMIF user clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cal_success` in 1: EMIF calibration passed.
- `chkr_clear_n` in 1: CSR clear/restart, active-low, synchronous to `clk`.
- `clear_busy` out 1: high while a pass is running.
- `chkr_error` out 1: sticky mismatch flag.
- `pass_done` out 1: level; pass finished.
- `err_addr` out ADDR_WIDTH: first failing word address (see Configuration).
- `err_count` out 16: count of mismatching beats, saturating (see Configuration).
- `avmm_read`, `avmm_write` out 1: AVMM commands.
- `avmm_address` out ADDR_WIDTH, `avmm_burstcount` out BURSTCOUNT_WIDTH, `avmm_writedata` out DATA_WIDTH, `avmm_byteenable` out BYTEENABLE_WIDTH.
- `avmm_waitrequest`, `avmm_readdatavalid` in 1; `avmm_readdata` in DATA_WIDTH.

## Operation
- States: IDLE, WRITE, READ, ABORT, DONE.
- IDLE → WRITE when `chkr_clear_n` = 1 and `cal_success` = 1.
- DONE holds until `chkr_clear_n` = 0, then goes to IDLE.
- `chkr_clear_n` = 0 in any state:
  - Clears `chkr_error`, `err_addr` and `err_count`.
  - In IDLE or DONE: go to IDLE.
  - In WRITE or READ: go to ABORT.
- Pattern for global beat index w (0 .. NUM_BURSTS·BURST_LEN−1): 32-bit lane k = {w[15:0], k[7:0], 8'hA5}.
- Burst b uses address BASE_ADDR + b·BURST_LEN. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- `avmm_byteenable` is all ones.
- WRITE:
  - Every beat asserts `avmm_write`. `avmm_address` and `avmm_burstcount` = BURST_LEN are held constant for the whole burst.
  - A beat advances only when `avmm_waitrequest` = 0.
  - After the last beat of burst NUM_BURSTS−1, go to READ.
- READ:
  - Issue one `avmm_read` per burst, held until `avmm_waitrequest` = 0, only while outstanding < MAX_OUTSTANDING.
  - Outstanding count increments on command acceptance and decrements on the last beat of a burst. When both happen in the same cycle, the count is unchanged.
  - Each `avmm_readdatavalid` beat is compared with the pattern for the expected-beat counter. Mismatch sets `chkr_error`.
  - When all NUM_BURSTS·BURST_LEN beats are received, go to DONE.
- ABORT:
  - If in a write burst: complete the remaining beats.
  - If in READ: issue no new commands and drain all outstanding beats. Drained beats are not compared.
  - Then go to IDLE.
- `clear_busy` = 1 in WRITE, READ, ABORT. `pass_done` = 1 in DONE.
- `cal_success` falling mid-pass is ignored. It only gates leaving IDLE.

## Timing
- Reset values:
  - State IDLE.
  - All AVMM command outputs 0. `avmm_burstcount` 0. `avmm_byteenable` all ones.
  - `clear_busy` = 0, `pass_done` = 0, `chkr_error` = 0, `err_addr` = 0, `err_count` = 0.
- All outputs are registered.
- First `avmm_write` appears one cycle after the IDLE→WRITE condition is sampled.
- Under zero waitrequest, write bursts are back-to-back with no idle cycle.
- Read commands can issue on consecutive cycles.
- `chkr_error` asserts on the cycle after the mismatching `avmm_readdatavalid` beat.
- `pass_done` asserts on the cycle after the final read beat.
- `chkr_clear_n` low clears error state on the next edge. Clearing has priority over a same-cycle mismatch.

## Configuration
- `EMIF_CHKR_ERR_CAPTURE_EN` defined:
  - `err_addr` latches the word address of the first mismatching beat.
  - `err_count` increments per mismatching beat and saturates at 16'hFFFF.
- Undefined: `err_addr` and `err_count` are tied to 0, with no capture logic. `chkr_error` behaves the same either way.

## Test plan
All scenarios use DATA_WIDTH = 512, BURST_LEN = 4, NUM_BURSTS = 4, ideal responder with 5-cycle read latency.
- Zero-waitrequest clean pass: 16 write beats in 16 consecutive cycles, then 4 reads → `pass_done` = 1, `chkr_error` = 0, `clear_busy` = 0.
- Random waitrequest (50%): address and burstcount are stable within every burst, and beat data matches the pattern for w = 0..15 → pass with no error.
- Responder flips bit 0 of beat w = 9:
  - `chkr_error` = 1 one cycle after that beat and stays high.
  - With the macro: `err_addr` = BASE_ADDR + 9, `err_count` = 1.
- MAX_OUTSTANDING = 2, read latency 20 cycles: never more than 2 read commands unacknowledged → pass completes.
- `chkr_clear_n` pulsed low during the 2nd write beat: remaining beats complete, then IDLE. On release a fresh pass runs to `pass_done`.
- `chkr_clear_n` low after 2 reads issued: no further reads, all 8 beats drained, `chkr_error` stays 0, state IDLE. `rst_n` asserted mid-READ → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/emif_avmm_mem_chkr.sv
// AVMM memory checker for one EMIF channel: writes a beat-indexed pattern over a region in bursts,
// reads it back and compares every beat. EMIF_CHKR_ERR_CAPTURE_EN adds first-fail address and mismatch count.
module emif_avmm_mem_chkr #(
    parameter int unsigned           ADDR_WIDTH       = 27,
    parameter int unsigned           DATA_WIDTH       = 512,
    parameter int unsigned           BURSTCOUNT_WIDTH = 7,
    parameter int unsigned           BYTEENABLE_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int unsigned           BURST_LEN        = 4,
    parameter int unsigned           NUM_BURSTS       = 1024,
    parameter int unsigned           MAX_OUTSTANDING  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cal_success,
    input  logic                        chkr_clear_n,
    output logic                        clear_busy,
    output logic                        chkr_error,
    output logic                        pass_done,
    output logic [ADDR_WIDTH-1:0]       err_addr,
    output logic [15:0]                 err_count,
    output logic                        avmm_read,
    output logic                        avmm_write,
    output logic [ADDR_WIDTH-1:0]       avmm_address,
    output logic [BURSTCOUNT_WIDTH-1:0] avmm_burstcount,
    output logic [DATA_WIDTH-1:0]       avmm_writedata,
    output logic [BYTEENABLE_WIDTH-1:0] avmm_byteenable,
    input  logic                        avmm_waitrequest,
    input  logic                        avmm_readdatavalid,
    input  logic [DATA_WIDTH-1:0]       avmm_readdata
);
    localparam int unsigned LANES  = DATA_WIDTH / 32;
    localparam int unsigned TOTAL  = NUM_BURSTS * BURST_LEN;
    localparam int unsigned BEAT_W = $clog2(TOTAL + 1);
    localparam int unsigned BB_W   = $clog2(BURST_LEN + 1);
    localparam int unsigned CMD_W  = $clog2(NUM_BURSTS + 1);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, ABORT, DONE} state_t;

    state_t                      state_q, state_d;
    logic                        avmm_write_q, avmm_write_d, avmm_read_q, avmm_read_d;
    logic [ADDR_WIDTH-1:0]       avmm_address_q, avmm_address_d;
    logic [BURSTCOUNT_WIDTH-1:0] avmm_burstcount_q, avmm_burstcount_d;
    logic [DATA_WIDTH-1:0]       avmm_writedata_q, avmm_writedata_d;
    logic [BEAT_W-1:0]           wbeat_q, wbeat_d, rbeat_q, rbeat_d;
    logic [BB_W-1:0]             wbib_q, wbib_d, rbib_q, rbib_d;
    logic [CMD_W-1:0]            rcmd_q, rcmd_d;
    logic [OUT_W-1:0]            outst_q, outst_d;
    logic                        chkr_error_q, chkr_error_d;
    logic                        clear_busy_q, clear_busy_d, pass_done_q, pass_done_d;
    logic                        wr_acc, rd_acc, rd_last, wr_burst_end, mismatch;

    // Lane k of beat w is {w[15:0], k[7:0], 8'hA5}
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] w);
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < int'(LANES); k++) p[k*32 +: 32] = {w[15:0], 8'(k), 8'hA5};
        return p;
    endfunction

    assign wr_acc       = avmm_write_q && !avmm_waitrequest;
    assign rd_acc       = avmm_read_q && !avmm_waitrequest;
    assign wr_burst_end = wr_acc && (wbib_q == BB_W'(BURST_LEN - 1));
    assign rd_last      = avmm_readdatavalid && (rbib_q == BB_W'(BURST_LEN - 1));
    assign mismatch     = (state_q == READ) && avmm_readdatavalid &&
                          (avmm_readdata != pattern(32'(rbeat_q)));

    always_comb begin
        state_d           = state_q;
        avmm_write_d      = avmm_write_q;
        avmm_read_d       = avmm_read_q;
        avmm_address_d    = avmm_address_q;
        avmm_writedata_d  = avmm_writedata_q;
        wbeat_d           = wbeat_q;
        wbib_d            = wbib_q;
        rcmd_d            = rcmd_q;
        rbeat_d           = rbeat_q;
        rbib_d            = rbib_q;
        outst_d           = outst_q + OUT_W'(rd_acc) - OUT_W'(rd_last);
        chkr_error_d      = (chkr_error_q || mismatch) && chkr_clear_n;

        if (avmm_readdatavalid) begin
            rbeat_d = rbeat_q + BEAT_W'(1);
            rbib_d  = rd_last ? '0 : rbib_q + BB_W'(1);
        end
        if (rd_acc) begin
            avmm_read_d = 1'b0;
            rcmd_d      = rcmd_q + CMD_W'(1);
        end
        // Write address and data advance per accepted beat; address steps once per burst
        if (wr_acc) begin
            wbeat_d          = wbeat_q + BEAT_W'(1);
            avmm_writedata_d = pattern(32'(wbeat_q) + 32'd1);
            wbib_d           = wbib_q + BB_W'(1);
            if (wr_burst_end) begin
                wbib_d         = '0;
                avmm_address_d = avmm_address_q + ADDR_WIDTH'(BURST_LEN);
            end
        end

        case (state_q)
            IDLE: begin
                if (chkr_clear_n && cal_success) begin
                    state_d          = WRITE;
                    avmm_write_d     = 1'b1;
                    avmm_address_d   = BASE_ADDR;
                    avmm_writedata_d = pattern(32'd0);
                    wbeat_d          = '0;
                    wbib_d           = '0;
                    rcmd_d           = '0;
                    rbeat_d          = '0;
                    rbib_d           = '0;
                    outst_d          = '0;
                end
            end
            WRITE: begin
                if (!chkr_clear_n) begin
                    state_d = ABORT;
                    if (wr_burst_end) avmm_write_d = 1'b0;
                end else if (wr_acc && wbeat_q == BEAT_W'(TOTAL - 1)) begin
                    state_d      = READ;
                    avmm_write_d = 1'b0;
                end
            end
            READ: begin
                if (!chkr_clear_n) state_d = ABORT;
                else if (avmm_readdatavalid && rbeat_q == BEAT_W'(TOTAL - 1)) state_d = DONE;
            end
            ABORT: begin
                if (wr_burst_end) avmm_write_d = 1'b0;
                if (!avmm_write_d && !avmm_read_d && outst_d == '0) state_d = IDLE;
            end
            DONE: begin
                if (!chkr_clear_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A held read stays on the bus until accepted; new reads only while under the outstanding limit
        if (state_d == READ && !avmm_read_d && rcmd_d < CMD_W'(NUM_BURSTS) &&
            outst_d < OUT_W'(MAX_OUTSTANDING)) begin
            avmm_read_d    = 1'b1;
            avmm_address_d = (rcmd_d == '0) ? BASE_ADDR : avmm_address_q + ADDR_WIDTH'(BURST_LEN);
        end

        avmm_burstcount_d = (avmm_write_d || avmm_read_d) ? BURSTCOUNT_WIDTH'(BURST_LEN) : '0;
        clear_busy_d      = (state_d == WRITE) || (state_d == READ) || (state_d == ABORT);
        pass_done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            avmm_write_q      <= 1'b0;
            avmm_read_q       <= 1'b0;
            avmm_address_q    <= '0;
            avmm_burstcount_q <= '0;
            avmm_writedata_q  <= '0;
            wbeat_q           <= '0;
            wbib_q            <= '0;
            rcmd_q            <= '0;
            rbeat_q           <= '0;
            rbib_q            <= '0;
            outst_q           <= '0;
            chkr_error_q      <= 1'b0;
            clear_busy_q      <= 1'b0;
            pass_done_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            avmm_write_q      <= avmm_write_d;
            avmm_read_q       <= avmm_read_d;
            avmm_address_q    <= avmm_address_d;
            avmm_burstcount_q <= avmm_burstcount_d;
            avmm_writedata_q  <= avmm_writedata_d;
            wbeat_q           <= wbeat_d;
            wbib_q            <= wbib_d;
            rcmd_q            <= rcmd_d;
            rbeat_q           <= rbeat_d;
            rbib_q            <= rbib_d;
            outst_q           <= outst_d;
            chkr_error_q      <= chkr_error_d;
            clear_busy_q      <= clear_busy_d;
            pass_done_q       <= pass_done_d;
        end
    end

`ifdef EMIF_CHKR_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [15:0]           err_count_q, err_count_d;

    // Beats are contiguous from BASE_ADDR, so the failing word address is BASE_ADDR + beat index
    always_comb begin
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (!chkr_clear_n) begin
            err_addr_d  = '0;
            err_count_d = '0;
        end else if (mismatch) begin
            if (!chkr_error_q) err_addr_d = BASE_ADDR + ADDR_WIDTH'(rbeat_q);
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
`else
    assign err_addr  = '0;
    assign err_count = '0;
`endif

    assign clear_busy      = clear_busy_q;
    assign chkr_error      = chkr_error_q;
    assign pass_done       = pass_done_q;
    assign avmm_read       = avmm_read_q;
    assign avmm_write      = avmm_write_q;
    assign avmm_address    = avmm_address_q;
    assign avmm_burstcount = avmm_burstcount_q;
    assign avmm_writedata  = avmm_writedata_q;
    assign avmm_byteenable = '1;
endmodule

// File: tb/tb_emif_avmm_mem_chkr.sv
// Bench for emif_avmm_mem_chkr: memory-backed AVMM responder with random waitrequest and
// configurable read latency; expected behaviour comes from a spec-level pattern/address model.
module tb_emif_avmm_mem_chkr;
    localparam int unsigned AW  = 27;
    localparam int unsigned DW  = 512;
    localparam int unsigned BCW = 7;
    localparam int unsigned BEW = 64;
    localparam int unsigned BL  = 4;
    localparam int unsigned NB  = 4;
    localparam int unsigned MAXO = 2;
    typedef logic [AW-1:0] addr_t;
    localparam addr_t BASE = 27'h7FF_FFF8;

    logic clk = 1'b0, rst_n = 1'b0, cal_success = 1'b1, chkr_clear_n = 1'b0;
    logic clear_busy, chkr_error, pass_done, avmm_read, avmm_write;
    logic [AW-1:0] err_addr, avmm_address;
    logic [15:0] err_count;
    logic [BCW-1:0] avmm_burstcount;
    logic [DW-1:0] avmm_writedata, avmm_readdata = '0;
    logic [BEW-1:0] avmm_byteenable;
    logic avmm_waitrequest = 1'b0, avmm_readdatavalid = 1'b0;

    emif_avmm_mem_chkr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BCW), .BYTEENABLE_WIDTH(BEW),
        .BASE_ADDR(BASE), .BURST_LEN(BL), .NUM_BURSTS(NB), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .cal_success(cal_success), .chkr_clear_n(chkr_clear_n),
        .clear_busy(clear_busy), .chkr_error(chkr_error), .pass_done(pass_done),
        .err_addr(err_addr), .err_count(err_count), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_address(avmm_address), .avmm_burstcount(avmm_burstcount), .avmm_writedata(avmm_writedata),
        .avmm_byteenable(avmm_byteenable), .avmm_waitrequest(avmm_waitrequest),
        .avmm_readdatavalid(avmm_readdatavalid), .avmm_readdata(avmm_readdata));

    initial forever #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, lat = 5, done_cyc = 0;
    bit wr_rand = 0, flip_en = 0, flip_seen = 0, err_at_flip = 0;
    int wcount, wbib, wr_err, first_wr_cyc, last_wr_cyc;
    int rd_cmds, rd_err, rbeats, rbib, outst, max_out, last_rd_cyc;
    addr_t wburst_addr;
    addr_t rd_addr_q[$];
    int rd_due_q[$];
    logic [DW-1:0] mem [int unsigned];

    function automatic logic [DW-1:0] exp_beat(input int unsigned w);
        logic [DW-1:0] b;
        b = '0;
        for (int k = 0; k < int'(DW / 32); k++) b[k*32 +: 32] = {w[15:0], 8'(k), 8'hA5};
        return b;
    endfunction

    task automatic model_reset();
        wcount = 0; wbib = 0; wr_err = 0; first_wr_cyc = -1; last_wr_cyc = -1;
        rd_cmds = 0; rd_err = 0; rbeats = 0; rbib = 0; outst = 0; max_out = 0; last_rd_cyc = -1;
        flip_seen = 0; err_at_flip = 0;
        rd_addr_q.delete(); rd_due_q.delete();
    endtask

    // Responder: decides this cycle's inputs at the falling edge and books what the next rising edge accepts
    always @(negedge clk) begin
        addr_t a;
        logic [DW-1:0] d;
        cyc++;
        if (!rst_n) begin
            avmm_waitrequest = 1'b0; avmm_readdatavalid = 1'b0;
        end else begin
            avmm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            if (avmm_write) begin
                if (wbib != 0 && (avmm_address !== wburst_addr || avmm_burstcount !== BCW'(BL))) wr_err++;
                if (!avmm_waitrequest) begin
                    if (wbib == 0) wburst_addr = avmm_address;
                    if (avmm_writedata !== exp_beat(wcount) || avmm_burstcount !== BCW'(BL)) wr_err++;
                    if (avmm_address !== BASE + addr_t'((wcount / BL) * BL)) wr_err++;
                    mem[32'(avmm_address + addr_t'(wbib))] = avmm_writedata;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                    wcount++;
                    wbib = (wbib + 1) % BL;
                end
            end
            if (avmm_read && !avmm_waitrequest) begin
                if (avmm_address !== BASE + addr_t'(rd_cmds * BL) || avmm_burstcount !== BCW'(BL)) rd_err++;
                rd_addr_q.push_back(avmm_address);
                rd_due_q.push_back(cyc + lat);
                rd_cmds++; outst++;
                if (outst > max_out) max_out = outst;
            end
            avmm_readdatavalid = 1'b0;
            avmm_readdata = {16{$urandom}};
            if (rd_addr_q.size() != 0 && cyc >= rd_due_q[0]) begin
                a = rd_addr_q[0] + addr_t'(rbib);
                d = mem.exists(32'(a)) ? mem[32'(a)] : '0;
                if (flip_en && rbeats == 9) begin
                    d[0] = ~d[0]; flip_seen = 1; err_at_flip = chkr_error;
                end
                avmm_readdatavalid = 1'b1; avmm_readdata = d;
                rbeats++; last_rd_cyc = cyc; rbib++;
                if (rbib == BL) begin
                    rbib = 0; outst--;
                    void'(rd_addr_q.pop_front()); void'(rd_due_q.pop_front());
                end
            end
        end
    end

    task automatic start_pass();
        chkr_clear_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chkr_clear_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (pass_done) begin ok = 1; done_cyc = cyc; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; chkr_clear_n = 1'b0; cal_success = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (avmm_write !== 1'b0 || avmm_read !== 1'b0) begin n_fail++; $display("FAIL rst_cmd got=%b%b want=00", avmm_write, avmm_read); end
        n_cmp++; if (avmm_burstcount !== '0) begin n_fail++; $display("FAIL rst_burstcount got=%0d want=0", avmm_burstcount); end
        n_cmp++; if (avmm_byteenable !== {BEW{1'b1}}) begin n_fail++; $display("FAIL rst_byteenable got=%h want=all ones", avmm_byteenable); end
        n_cmp++; if ({clear_busy, pass_done, chkr_error} !== 3'b000) begin n_fail++; $display("FAIL rst_status got=%b want=000", {clear_busy, pass_done, chkr_error}); end
        n_cmp++; if (err_addr !== '0 || err_count !== '0) begin n_fail++; $display("FAIL rst_errcap got=%h/%0d want=0/0", err_addr, err_count); end
        rst_n = 1'b1; chkr_clear_n = 1'b1;
        model_reset();
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (clear_busy !== 1'b0 || wcount !== 0) begin n_fail++; $display("FAIL cal_gate got busy=%b writes=%0d want=0/0", clear_busy, wcount); end
        cal_success = 1'b1;
    endtask

    task automatic test_clean_pass();
        bit ok;
        lat = 5; wr_rand = 0; flip_en = 0;
        start_pass();
        wait_done(2000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL clean_done got=0 want=1"); end
        n_cmp++; if (chkr_error !== 1'b0 || clear_busy !== 1'b0) begin n_fail++; $display("FAIL clean_status got err=%b busy=%b want=0/0", chkr_error, clear_busy); end
        n_cmp++; if (wcount !== 16 || last_wr_cyc - first_wr_cyc !== 15) begin n_fail++; $display("FAIL clean_b2b got beats=%0d span=%0d want=16/15", wcount, last_wr_cyc - first_wr_cyc); end
        n_cmp++; if (wr_err !== 0 || rd_err !== 0) begin n_fail++; $display("FAIL clean_bus got wr_err=%0d rd_err=%0d want=0/0", wr_err, rd_err); end
        n_cmp++; if (rd_cmds !== 4 || rbeats !== 16) begin n_fail++; $display("FAIL clean_reads got cmds=%0d beats=%0d want=4/16", rd_cmds, rbeats); end
        n_cmp++; if (done_cyc !== last_rd_cyc) begin n_fail++; $display("FAIL clean_done_latency got=%0d want=%0d", done_cyc, last_rd_cyc); end
        n_cmp++; if (err_addr !== '0 || err_count !== '0) begin n_fail++; $display("FAIL clean_errcap got=%h/%0d want=0/0", err_addr, err_count); end
    endtask

    task automatic test_random_wait();
        bit ok;
        lat = 5; wr_rand = 1; flip_en = 0;
        start_pass();
        wait_done(4000, ok);
        wr_rand = 0;
        n_cmp++; if (!ok || chkr_error !== 1'b0) begin n_fail++; $display("FAIL rwait_done got done=%b err=%b want=1/0", ok, chkr_error); end
        n_cmp++; if (wr_err !== 0 || wcount !== 16) begin n_fail++; $display("FAIL rwait_writes got err=%0d beats=%0d want=0/16", wr_err, wcount); end
        n_cmp++; if (rd_err !== 0 || rd_cmds !== 4) begin n_fail++; $display("FAIL rwait_reads got err=%0d cmds=%0d want=0/4", rd_err, rd_cmds); end
    endtask

    task automatic test_bitflip();
        bit ok;
        addr_t exp_addr;
        logic [15:0] exp_cnt;
        lat = 5; wr_rand = 0; flip_en = 1;
        start_pass();
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (flip_seen) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL flip_seen got=0 want=1"); end
        n_cmp++; if (err_at_flip !== 1'b0 || chkr_error !== 1'b1) begin n_fail++; $display("FAIL flip_timing got before=%b after=%b want=0/1", err_at_flip, chkr_error); end
        wait_done(2000, ok);
        flip_en = 0;
        n_cmp++; if (!ok || chkr_error !== 1'b1) begin n_fail++; $display("FAIL flip_sticky got done=%b err=%b want=1/1", ok, chkr_error); end
`ifdef EMIF_CHKR_ERR_CAPTURE_EN
        exp_addr = BASE + addr_t'(9); exp_cnt = 16'd1;
`else
        exp_addr = '0; exp_cnt = 16'd0;
`endif
        n_cmp++; if (err_addr !== exp_addr) begin n_fail++; $display("FAIL flip_err_addr got=%h want=%h", err_addr, exp_addr); end
        n_cmp++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL flip_err_count got=%0d want=%0d", err_count, exp_cnt); end
        chkr_clear_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (chkr_error !== 1'b0 || err_count !== '0) begin n_fail++; $display("FAIL flip_clear got err=%b cnt=%0d want=0/0", chkr_error, err_count); end
    endtask

    task automatic test_max_outstanding();
        bit ok;
        lat = 20; wr_rand = 0; flip_en = 0;
        start_pass();
        wait_done(4000, ok);
        n_cmp++; if (!ok || chkr_error !== 1'b0) begin n_fail++; $display("FAIL maxo_done got done=%b err=%b want=1/0", ok, chkr_error); end
        n_cmp++; if (max_out !== int'(MAXO)) begin n_fail++; $display("FAIL maxo_peak got=%0d want=%0d", max_out, MAXO); end
        lat = 5;
    endtask

    task automatic test_abort_write();
        bit ok;
        lat = 5; wr_rand = 0;
        start_pass();
        for (int i = 0; i < 100 && wcount < 1; i++) begin @(posedge clk); #1; end
        chkr_clear_n = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!clear_busy) begin ok = 1; break; end
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (!ok || wcount !== int'(BL)) begin n_fail++; $display("FAIL abw_burst got idle=%b beats=%0d want=1/%0d", ok, wcount, BL); end
        n_cmp++; if (avmm_write !== 1'b0 || pass_done !== 1'b0 || rd_cmds !== 0) begin n_fail++; $display("FAIL abw_idle got wr=%b done=%b rd=%0d want=0/0/0", avmm_write, pass_done, rd_cmds); end
        model_reset();
        chkr_clear_n = 1'b1;
        wait_done(2000, ok);
        n_cmp++; if (!ok || wcount !== 16 || chkr_error !== 1'b0) begin n_fail++; $display("FAIL abw_rerun got done=%b beats=%0d err=%b want=1/16/0", ok, wcount, chkr_error); end
    endtask

    task automatic test_abort_read();
        bit ok;
        lat = 5; wr_rand = 0;
        start_pass();
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (rd_cmds == 1 && avmm_read) begin ok = 1; break; end
        end
        chkr_clear_n = 1'b0;
        for (int i = 0; i < 200; i++) begin @(posedge clk); #1; if (!clear_busy) break; end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (!ok || rd_cmds !== 2) begin n_fail++; $display("FAIL abr_cmds got seen=%b cmds=%0d want=1/2", ok, rd_cmds); end
        n_cmp++; if (rbeats !== 8 || outst !== 0) begin n_fail++; $display("FAIL abr_drain got beats=%0d outst=%0d want=8/0", rbeats, outst); end
        n_cmp++; if ({clear_busy, pass_done, chkr_error, avmm_read} !== 4'b0000) begin n_fail++; $display("FAIL abr_idle got=%b want=0000", {clear_busy, pass_done, chkr_error, avmm_read}); end
    endtask

    task automatic test_async_reset();
        bit ok;
        lat = 20; wr_rand = 0;
        start_pass();
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (rd_cmds >= 1) begin ok = 1; break; end
        end
        n_cmp++; if (!ok || clear_busy !== 1'b1) begin n_fail++; $display("FAIL ares_inread got seen=%b busy=%b want=1/1", ok, clear_busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({clear_busy, pass_done, chkr_error, avmm_read, avmm_write} !== 5'b00000) begin n_fail++; $display("FAIL ares_status got=%b want=00000", {clear_busy, pass_done, chkr_error, avmm_read, avmm_write}); end
        n_cmp++; if (avmm_burstcount !== '0 || avmm_byteenable !== {BEW{1'b1}}) begin n_fail++; $display("FAIL ares_bus got bc=%0d be=%h want=0/all ones", avmm_burstcount, avmm_byteenable); end
        repeat (2) @(posedge clk);
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_pass();
        test_random_wait();
        test_bitflip();
        test_max_outstanding();
        test_abort_write();
        test_abort_read();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
